// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants, types and helpers for the reservation
//                stations, ROB and LSB. Default widths live here so all
//                blocks agree on tag/opcode/data sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_pkg;

    localparam int c_rs_size_def   = 16;
    localparam int c_rob_tag_w_def = 4;
    localparam int c_op_w_def      = 6;
    localparam int c_data_w_def    = 32;
    localparam int c_num_cdb_def   = 2;

    // Ceilings for the tag matcher; NUM_CDB and ROB_TAG_W must not exceed these.
    localparam int c_cdb_max   = 8;
    localparam int c_tag_max_w = 8;
    localparam int c_cdb_idx_w = 3;

    // Tag value meaning "no dependency / invalid".
    localparam logic [c_tag_max_w-1:0] c_zero_tag = '0;
    localparam logic [c_op_w_def-1:0]  c_op_nop   = '0;

    typedef struct packed {
        logic                   hit;
        logic [c_cdb_idx_w-1:0] idx;
    } cdb_hit_t;

    // Compare one operand tag against every active CDB channel. Channels are
    // scanned from the top down so the lowest matching channel wins.
    function automatic cdb_hit_t cdb_match(
        input logic [c_tag_max_w-1:0]           tag,
        input logic [c_cdb_max*c_tag_max_w-1:0] cdb_tags,
        input int                               num_cdb,
        input int                               tag_w
    );
        cdb_hit_t                r;
        logic [c_tag_max_w-1:0]  t;
        logic [c_tag_max_w-1:0]  mask;
        r    = '0;
        mask = c_tag_max_w'((64'd1 << tag_w) - 64'd1);
        for (int k = c_cdb_max - 1; k >= 0; k--) begin
            t = c_tag_max_w'(cdb_tags >> (k * tag_w)) & mask;
            if (k < num_cdb && tag != c_zero_tag && t == tag) begin
                r.hit = 1'b1;
                r.idx = c_cdb_idx_w'(k);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_lsb.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_lsb
//  Description : Lowest-set-bit priority encoder with a found flag.
//  Ports       : i_req   request vector
//                o_found any request bit set
//                o_idx   index of the lowest set bit (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc_lsb #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        // Descending scan: the last assignment is the lowest set bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module      : rs_multi_cdb
//  Description : ALU reservation station watching NUM_CDB result buses.
//                Holds decoded ops until both operands resolve, issues the
//                lowest-index ready entry each cycle, bypasses CDB results at
//                insertion, flushes on clear, reports occupancy.
//  Ports       : clk/rst/rdy/clear  control (rst sync active-high, rdy=0 freezes)
//                in_*               insert request and CDB broadcast inputs
//                out_has_free/count occupancy to fetch
//                out_alu_*          registered issue to the ALU
//  Revision    : 1.0  initial release
// ============================================================================
module rs_multi_cdb
    import rs_pkg::*;
#(
    parameter int RS_SIZE   = c_rs_size_def,
    parameter int ROB_TAG_W = c_rob_tag_w_def,
    parameter int OP_W      = c_op_w_def,
    parameter int DATA_W    = c_data_w_def,
    parameter int NUM_CDB   = c_num_cdb_def
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [ROB_TAG_W-1:0]          in_rob_tag,
    input  logic [OP_W-1:0]               in_op,
    input  logic [DATA_W-1:0]             in_value1,
    input  logic [DATA_W-1:0]             in_value2,
    input  logic [ROB_TAG_W-1:0]          in_tag1,
    input  logic [ROB_TAG_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]             in_imm,
    input  logic [DATA_W-1:0]             in_pc,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]  in_cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     in_cdb_value,
    output logic                          out_has_free,
    output logic [$clog2(RS_SIZE+1)-1:0]  out_count,
    output logic                          out_alu_valid,
    output logic [OP_W-1:0]               out_alu_op,
    output logic [DATA_W-1:0]             out_alu_value1,
    output logic [DATA_W-1:0]             out_alu_value2,
    output logic [DATA_W-1:0]             out_alu_imm,
    output logic [ROB_TAG_W-1:0]          out_alu_rob_tag,
    output logic [DATA_W-1:0]             out_alu_pc
);

    localparam int c_cnt_w = $clog2(RS_SIZE + 1);
    localparam int c_idx_w = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int c_cdb_w = c_cdb_max * c_tag_max_w;
    localparam logic [OP_W-1:0] c_nop = OP_W'(c_op_nop);

    // Entry storage
    logic [RS_SIZE-1:0]   r_busy;
    logic [OP_W-1:0]      r_op   [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_rob  [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_tag1 [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_tag2 [RS_SIZE];
    logic [DATA_W-1:0]    r_val1 [RS_SIZE];
    logic [DATA_W-1:0]    r_val2 [RS_SIZE];
    logic [DATA_W-1:0]    r_imm  [RS_SIZE];
    logic [DATA_W-1:0]    r_pc   [RS_SIZE];
    logic [c_cnt_w-1:0]   r_count;

    logic [DATA_W-1:0]    w_cdb_val [NUM_CDB];
    logic [c_cdb_w-1:0]   w_cdb_tags;
    logic [RS_SIZE-1:0]   w_ready;
    logic [RS_SIZE-1:0]   w_wake1;
    logic [RS_SIZE-1:0]   w_wake2;
    logic [DATA_W-1:0]    w_wv1 [RS_SIZE];
    logic [DATA_W-1:0]    w_wv2 [RS_SIZE];
    logic [DATA_W-1:0]    w_in_val1;
    logic [DATA_W-1:0]    w_in_val2;
    logic [ROB_TAG_W-1:0] w_in_tag1;
    logic [ROB_TAG_W-1:0] w_in_tag2;
    logic                 w_free_found;
    logic [c_idx_w-1:0]   w_free_idx;
    logic                 w_iss_found;
    logic [c_idx_w-1:0]   w_iss_idx;
    logic                 w_ins;

    generate
        for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb_unpack
            assign w_cdb_val[k] = in_cdb_value[k*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_cdb_tags = c_cdb_w'(in_cdb_tag);

    // Wakeup matches for stored entries and bypass for the incoming op.
    always_comb begin
        cdb_hit_t h1;
        cdb_hit_t h2;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && (r_tag1[i] == '0) && (r_tag2[i] == '0);
            h1 = cdb_match(c_tag_max_w'(r_tag1[i]), w_cdb_tags, NUM_CDB, ROB_TAG_W);
            h2 = cdb_match(c_tag_max_w'(r_tag2[i]), w_cdb_tags, NUM_CDB, ROB_TAG_W);
            w_wake1[i] = h1.hit;
            w_wake2[i] = h2.hit;
            w_wv1[i]   = '0;
            w_wv2[i]   = '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                if (h1.idx == c_cdb_idx_w'(k)) w_wv1[i] = w_cdb_val[k];
                if (h2.idx == c_cdb_idx_w'(k)) w_wv2[i] = w_cdb_val[k];
            end
        end

        h1 = cdb_match(c_tag_max_w'(in_tag1), w_cdb_tags, NUM_CDB, ROB_TAG_W);
        h2 = cdb_match(c_tag_max_w'(in_tag2), w_cdb_tags, NUM_CDB, ROB_TAG_W);
        w_in_val1 = in_value1;
        w_in_val2 = in_value2;
        w_in_tag1 = in_tag1;
        w_in_tag2 = in_tag2;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (h1.hit && h1.idx == c_cdb_idx_w'(k)) begin
                w_in_val1 = w_cdb_val[k];
                w_in_tag1 = '0;
            end
            if (h2.hit && h2.idx == c_cdb_idx_w'(k)) begin
                w_in_val2 = w_cdb_val[k];
                w_in_tag2 = '0;
            end
        end
    end

    prio_enc_lsb #(.WIDTH(RS_SIZE), .IDX_W(c_idx_w)) u_free_sel (
        .i_req   (~r_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    prio_enc_lsb #(.WIDTH(RS_SIZE), .IDX_W(c_idx_w)) u_issue_sel (
        .i_req   (w_ready),
        .o_found (w_iss_found),
        .o_idx   (w_iss_idx)
    );

    // Free slot comes from registered busy, so it never aliases the issuing entry.
    assign w_ins        = in_valid && w_free_found;
    assign out_has_free = w_free_found;
    assign out_count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy          <= '0;
            r_count         <= '0;
            out_alu_valid   <= 1'b0;
            out_alu_op      <= c_nop;
            out_alu_value1  <= '0;
            out_alu_value2  <= '0;
            out_alu_imm     <= '0;
            out_alu_rob_tag <= '0;
            out_alu_pc      <= '0;
        end else if (clear) begin
            r_busy        <= '0;
            r_count       <= '0;
            out_alu_valid <= 1'b0;
        end else if (!rdy) begin
            out_alu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && w_wake1[i]) begin
                    r_val1[i] <= w_wv1[i];
                    r_tag1[i] <= '0;
                end
                if (r_busy[i] && w_wake2[i]) begin
                    r_val2[i] <= w_wv2[i];
                    r_tag2[i] <= '0;
                end
            end

            if (w_iss_found) begin
                out_alu_valid     <= 1'b1;
                out_alu_op        <= r_op[w_iss_idx];
                out_alu_value1    <= r_val1[w_iss_idx];
                out_alu_value2    <= r_val2[w_iss_idx];
                out_alu_imm       <= r_imm[w_iss_idx];
                out_alu_rob_tag   <= r_rob[w_iss_idx];
                out_alu_pc        <= r_pc[w_iss_idx];
                r_busy[w_iss_idx] <= 1'b0;
            end else begin
                out_alu_valid <= 1'b0;
                out_alu_op    <= c_nop;
            end

            if (w_ins) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= in_op;
                r_rob[w_free_idx]  <= in_rob_tag;
                r_tag1[w_free_idx] <= w_in_tag1;
                r_tag2[w_free_idx] <= w_in_tag2;
                r_val1[w_free_idx] <= w_in_val1;
                r_val2[w_free_idx] <= w_in_val2;
                r_imm[w_free_idx]  <= in_imm;
                r_pc[w_free_idx]   <= in_pc;
            end

            r_count <= r_count + c_cnt_w'(w_ins) - c_cnt_w'(w_iss_found);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_multi_cdb
//  Description : Directed self-checking bench for rs_multi_cdb with an
//                issue scoreboard (expected op, operands and issue cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_multi_cdb;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_rob_tag;
    logic [5:0]  in_op;
    logic [31:0] in_value1;
    logic [31:0] in_value2;
    logic [3:0]  in_tag1;
    logic [3:0]  in_tag2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [7:0]  in_cdb_tag;
    logic [63:0] in_cdb_value;
    logic        out_has_free;
    logic [4:0]  out_count;
    logic        out_alu_valid;
    logic [5:0]  out_alu_op;
    logic [31:0] out_alu_value1;
    logic [31:0] out_alu_value2;
    logic [31:0] out_alu_imm;
    logic [3:0]  out_alu_rob_tag;
    logic [31:0] out_alu_pc;

    rs_multi_cdb dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_rob_tag      (in_rob_tag),
        .in_op           (in_op),
        .in_value1       (in_value1),
        .in_value2       (in_value2),
        .in_tag1         (in_tag1),
        .in_tag2         (in_tag2),
        .in_imm          (in_imm),
        .in_pc           (in_pc),
        .in_cdb_tag      (in_cdb_tag),
        .in_cdb_value    (in_cdb_value),
        .out_has_free    (out_has_free),
        .out_count       (out_count),
        .out_alu_valid   (out_alu_valid),
        .out_alu_op      (out_alu_op),
        .out_alu_value1  (out_alu_value1),
        .out_alu_value2  (out_alu_value2),
        .out_alu_imm     (out_alu_imm),
        .out_alu_rob_tag (out_alu_rob_tag),
        .out_alu_pc      (out_alu_pc)
    );

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] imm_of(input logic [3:0] rob);
        return 32'(rob) * 32'd16 + 32'd1;
    endfunction

    function automatic logic [31:0] pc_of(input logic [3:0] rob);
        return 32'h1000 + 32'(rob) * 32'd4;
    endfunction

    task automatic ins(input logic [5:0] op, input logic [3:0] rob,
                       input logic [3:0] t1, input logic [31:0] v1,
                       input logic [3:0] t2, input logic [31:0] v2);
        in_valid   = 1'b1;
        in_op      = op;
        in_rob_tag = rob;
        in_tag1    = t1;
        in_value1  = v1;
        in_tag2    = t2;
        in_value2  = v2;
        in_imm     = imm_of(rob);
        in_pc      = pc_of(rob);
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [3:0] rob,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input int at_cyc);
        exp_t e;
        e.op  = op;
        e.rob = rob;
        e.v1  = v1;
        e.v2  = v2;
        e.imm = imm_of(rob);
        e.pc  = pc_of(rob);
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        in_cdb_tag[ch*4 +: 4]    = tag;
        in_cdb_value[ch*32 +: 32] = val;
    endtask

    // One clock edge passes; outputs are sampled at the following negedge.
    task automatic step();
        @(negedge clk);
        in_valid     = 1'b0;
        in_cdb_tag   = '0;
        in_cdb_value = '0;
        clear        = 1'b0;
    endtask

    // Issue monitor: every strobe must match the head of the scoreboard,
    // and an expected issue that does not appear on time is reported.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_alu_valid) begin
                chk("issue_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("issue_cycle",  64'(cyc),             64'(e.cyc));
                    chk("issue_op",     64'(out_alu_op),      64'(e.op));
                    chk("issue_rob",    64'(out_alu_rob_tag), 64'(e.rob));
                    chk("issue_value1", 64'(out_alu_value1),  64'(e.v1));
                    chk("issue_value2", 64'(out_alu_value2),  64'(e.v2));
                    chk("issue_imm",    64'(out_alu_imm),     64'(e.imm));
                    chk("issue_pc",     64'(out_alu_pc),      64'(e.pc));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("issue_missing", 64'(out_alu_valid), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rob_tag = '0; in_tag1 = '0; in_tag2 = '0;
        in_value1 = '0; in_value2 = '0; in_imm = '0; in_pc = '0;
        in_cdb_tag = '0; in_cdb_value = '0;
        step();
        step();
        chk("rst_count",     64'(out_count),       64'd0);
        chk("rst_has_free",  64'(out_has_free),    64'd1);
        chk("rst_valid",     64'(out_alu_valid),   64'd0);
        chk("rst_op",        64'(out_alu_op),      64'd0);
        chk("rst_value1",    64'(out_alu_value1),  64'd0);
        chk("rst_rob",       64'(out_alu_rob_tag), 64'd0);
        rst = 1'b0;
        step();

        // Ready-on-insert op issues one edge after insertion.
        ins(6'd1, 4'd3, 4'd0, 32'd5, 4'd0, 32'd7);
        expect_issue(6'd1, 4'd3, 32'd5, 32'd7, cyc + 2);
        step();
        chk("t1_count_after_insert", 64'(out_count), 64'd1);
        step();
        chk("t1_count_after_issue", 64'(out_count), 64'd0);
        step();
        chk("t1_valid_idle", 64'(out_alu_valid), 64'd0);
        chk("t1_op_nop",     64'(out_alu_op),    64'd0);

        // Wakeup from channel 1; channel 0 carries a distracting value.
        ins(6'd2, 4'd5, 4'd4, 32'd0, 4'd0, 32'd9);
        step();
        step();
        step();
        chk("t2_waiting", 64'(out_count), 64'd1);
        cdb(1, 4'd4, 32'hDEAD);
        cdb(0, 4'd0, 32'h1111);
        expect_issue(6'd2, 4'd5, 32'hDEAD, 32'd9, cyc + 2);
        step();
        step();
        step();

        // Same-cycle bypass at insertion.
        ins(6'd3, 4'd7, 4'd0, 32'd11, 4'd6, 32'd0);
        cdb(0, 4'd6, 32'd42);
        expect_issue(6'd3, 4'd7, 32'd11, 32'd42, cyc + 2);
        step();
        step();
        step();
        chk("t3_count", 64'(out_count), 64'd0);

        // Fill every entry with an unresolved tag.
        for (int i = 0; i < 16; i++) begin
            ins(6'(i + 16), 4'((i % 15) + 1), 4'd9, 32'd0, 4'd0, 32'(100 + i));
            step();
        end
        chk("t4_full_has_free", 64'(out_has_free), 64'd0);
        chk("t4_full_count",    64'(out_count),    64'd16);
        ins(6'd1, 4'd1, 4'd0, 32'd1, 4'd0, 32'd2);
        step();
        chk("t4_drop_count", 64'(out_count), 64'd16);
        step();
        chk("t4_drop_count2", 64'(out_count), 64'd16);
        c0 = cyc;
        cdb(0, 4'd9, 32'h99);
        for (int i = 0; i < 16; i++)
            expect_issue(6'(i + 16), 4'((i % 15) + 1), 32'h99, 32'(100 + i), c0 + 2 + i);
        step();
        chk("t4_still_full", 64'(out_count), 64'd16);
        repeat (17) step();
        chk("t4_drained_count", 64'(out_count),    64'd0);
        chk("t4_drained_free",  64'(out_has_free), 64'd1);

        // Clear with pending entries, one ready, and a concurrent insert.
        for (int i = 0; i < 4; i++) begin
            ins(6'd4, 4'(i + 1), 4'd12, 32'd0, 4'd0, 32'd0);
            step();
        end
        ins(6'd5, 4'd8, 4'd0, 32'd1, 4'd0, 32'd2);
        step();
        chk("t5_count_before", 64'(out_count), 64'd5);
        clear = 1'b1;
        ins(6'd6, 4'd9, 4'd0, 32'd3, 4'd0, 32'd4);
        step();
        chk("t5_count_clear", 64'(out_count),     64'd0);
        chk("t5_valid_clear", 64'(out_alu_valid), 64'd0);
        step();
        chk("t5_valid_after", 64'(out_alu_valid), 64'd0);
        chk("t5_count_after", 64'(out_count),     64'd0);
        cdb(0, 4'd12, 32'd5);
        step();
        step();
        step();

        // Broadcast during rdy=0 is ignored.
        ins(6'd7, 4'd2, 4'd13, 32'd0, 4'd0, 32'd3);
        step();
        rdy = 1'b0;
        cdb(0, 4'd13, 32'd77);
        step();
        chk("t6_freeze_count", 64'(out_count),     64'd1);
        chk("t6_freeze_valid", 64'(out_alu_valid), 64'd0);
        rdy = 1'b1;
        step();
        step();
        step();
        chk("t6_still_waiting", 64'(out_count), 64'd1);

        // Real wakeup, then a freeze delays the issue by two cycles.
        cdb(0, 4'd13, 32'd88);
        expect_issue(6'd7, 4'd2, 32'd88, 32'd3, cyc + 4);
        step();
        rdy = 1'b0;
        step();
        chk("t6_ready_frozen", 64'(out_alu_valid), 64'd0);
        step();
        rdy = 1'b1;
        step();
        step();
        chk("t6_count_end", 64'(out_count), 64'd0);

        repeat (3) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
- Parametrised reservation station for the ALU path of the out-of-order core.
- Buffers decoded ALU ops until both source operands are resolved, then issues one ready entry per cycle to the ALU.
- Watches NUM_CDB result buses for operand wakeup, including same-cycle bypass at insertion.
- Supports full flush on branch mispredict and reports occupancy to the fetcher.

Parameters:
- RS_SIZE, 16: number of entries. All indices 0..RS_SIZE-1 are usable.
- ROB_TAG_W, 4: ROB tag width. Tag 0 means "no dependency / invalid".
- OP_W, 6: internal opcode width.
- DATA_W, 32: data width.
- NUM_CDB, 2: number of CDB channels (ALU, LSB, ...).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable. Low means freeze.
- clear  in  1  flush (mispredict). Synchronous.
- in_valid  in  1  insert request from decode.
- in_rob_tag  in  ROB_TAG_W  destination ROB tag (nonzero when in_valid).
- in_op  in  OP_W  opcode.
- in_value1, in_value2  in  DATA_W each  operand values (valid when the matching tag is 0).
- in_tag1, in_tag2  in  ROB_TAG_W each  operand producer tags. 0 means the value is ready.
- in_imm  in  DATA_W  immediate.
- in_pc  in  DATA_W  instruction PC.
- in_cdb_tag  in  NUM_CDB*ROB_TAG_W  packed CDB tags. Channel k occupies bits [k*ROB_TAG_W +: ROB_TAG_W]. 0 means idle.
- in_cdb_value  in  NUM_CDB*DATA_W  packed CDB values, same packing.
- out_has_free  out  1  at least one entry not busy (registered state).
- out_count  out  $clog2(RS_SIZE+1)  number of busy entries.
- out_alu_valid  out  1  issue strobe.
- out_alu_op  out  OP_W  issued opcode.
- out_alu_value1, out_alu_value2  out  DATA_W each  issued operands.
- out_alu_imm  out  DATA_W  issued immediate.
- out_alu_rob_tag  out  ROB_TAG_W  issued ROB tag.
- out_alu_pc  out  DATA_W  issued PC.

Behaviour:
- Priority order: rst > clear > !rdy > normal operation.
- Reset:
  - All busy bits cleared; out_count=0; out_has_free=1; out_alu_valid=0.
  - out_alu_op=NOP; all other out_alu_* fields = 0.
- Clear:
  - All busy bits cleared; out_alu_valid=0.
  - Insert and issue in that cycle are discarded.
- rdy low:
  - No entry state changes.
  - out_alu_valid<=0; other out_alu_* fields hold.
- Ready condition: entry i is ready when busy[i] && tag1[i]==0 && tag2[i]==0, using registered state.
- Issue:
  - The lowest-index ready entry is selected.
  - At the next edge, out_alu_* are registered from that entry, out_alu_valid=1, and the entry's busy bit clears.
  - With no ready entry, out_alu_valid=0 and out_alu_op=NOP.
  - Latency: an entry inserted with both tags 0 at edge N appears on out_alu_* after edge N+1.
- Insert:
  - When in_valid and a free slot exists, write the lowest-index non-busy entry.
  - in_valid while full (out_has_free=0) is dropped; upstream must gate on out_has_free.
  - The slot freed by an issue in the same cycle is not reusable until the next cycle.
- Insert bypass: if in_tagX != 0 equals a nonzero in_cdb_tag[k] in the same cycle, store the CDB value and tagX=0.
- Wakeup:
  - For every busy entry and each channel k with in_cdb_tag[k] != 0: a matching tag1 takes in_cdb_value[k] and tag1 becomes 0; tag2 behaves the same.
  - Each operand uses its own channel's value on each side.
  - Wakeup applies at the edge; a woken entry is issue-eligible in the following cycle.
- Duplicate tags on several channels: the lowest channel index wins (legal but unexpected).
- Simultaneous issue + insert + wakeup are all honoured in one edge. Issue and insert always target different entries.
- out_count is updated as count + inserted − issued. It never exceeds RS_SIZE and never underflows.

Decomposition:
- Package rs_pkg:
  - ZERO_TAG=0.
  - NOP opcode value.
  - Default widths, shared with the ROB and LSB.
  - Function cdb_match(tag, cdb_tags) returning a hit flag and channel index.
- Sub-module prio_enc_lsb:
  - Parametrised lowest-set-bit encoder with a found flag.
  - Instantiated twice: free-slot select (~busy) and issue select (ready).

Test Plan:
1. Reset, then insert op=ADD, tags 0, v1=5, v2=7, rob 3 at cycle 0. Required: out_alu_valid=1, op=ADD, v1=5, v2=7, rob_tag=3 after the cycle-1 edge, then valid=0 and out_count=0.
2. Insert with tag1=4, then drive in_cdb_tag ch1=4, value 0xDEAD two cycles later. Required: issue one cycle after the CDB with value1=0xDEAD.
3. Insert tag2=6 while ch0 broadcasts tag 6, value 42, in the same cycle. Required: the entry issues next cycle with value2=42 (bypass).
4. Fill all 16 entries with unresolved tags. Required: out_has_free=0 and out_count=16; a 17th in_valid changes nothing. Then broadcast one tag: issues are in lowest-index order.
5. With 5 busy entries and one ready, assert clear together with in_valid. Required: next cycle out_count=0, out_alu_valid=0, and the new entry is absent.
6. Hold rdy=0 during a CDB broadcast that matches an entry's tag. Required: no wakeup; after rdy returns, the entry still waits on its tag.
